// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encodings, line levels and parity modes.
// Used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    T_IDLE   = 3'd0,
    T_START  = 3'd1,
    T_DATA   = 3'd2,
    T_PARITY = 3'd3,
    T_STOP   = 3'd4
  } tx_state_e;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;

  localparam int PAR_MODE_EVEN = 0;
  localparam int PAR_MODE_ODD  = 1;

endpackage

// File: rtl/uart_tx_if.sv
// Producer-side byte handshake of the UART transmitter (valid/ready with data).
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] i_tx_data;
  logic                 i_tx_valid;
  logic                 o_tx_ready;

  modport master (output i_tx_data, output i_tx_valid, input o_tx_ready);
  modport slave  (input i_tx_data, input i_tx_valid, output o_tx_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter with a one-entry holding register; frames advance only on i_bd ticks.
// Start bit follows accept on the next i_bd; producer stalls only while a byte is held.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = PAR_MODE_EVEN,
  parameter int STOP_BITS  = 1
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_bd,
  uart_tx_if.slave  tx_if,
  output logic      o_tx,
  output logic      o_busy,
  output logic      o_done
);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_vld_q, hold_vld_d;
  logic                 hold_par_q, hold_par_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [2:0]           bitcnt_q, bitcnt_d;
  logic [1:0]           stopcnt_q, stopcnt_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 load;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    hold_par_d = hold_par_q;
    shift_d    = shift_q;
    par_d      = par_q;
    bitcnt_d   = bitcnt_q;
    stopcnt_d  = stopcnt_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    load       = 1'b0;

    // Accept and load are mutually exclusive: one needs the holder empty, the other full.
    if (tx_if.i_tx_valid && !hold_vld_q) begin
      hold_d     = tx_if.i_tx_data;
      hold_vld_d = 1'b1;
      hold_par_d = (^tx_if.i_tx_data) ^ (PARITY_ODD != 0);
    end

    case (state_q)
      T_IDLE: begin
        tx_d = UART_IDLE_LVL;
        if (i_bd && hold_vld_q) begin
          load = 1'b1;
        end
      end
      T_START: begin
        if (i_bd) begin
          tx_d     = shift_q[0];
          bitcnt_d = 3'd0;
          state_d  = T_DATA;
        end
      end
      T_DATA: begin
        if (i_bd) begin
          if (bitcnt_q < 3'(DATA_BITS - 1)) begin
            shift_d  = shift_q >> 1;
            tx_d     = shift_q[1];
            bitcnt_d = bitcnt_q + 3'd1;
          end else if (PARITY_EN != 0) begin
            tx_d    = par_q;
            state_d = T_PARITY;
          end else begin
            tx_d      = UART_IDLE_LVL;
            stopcnt_d = 2'd0;
            state_d   = T_STOP;
          end
        end
      end
      T_PARITY: begin
        if (i_bd) begin
          tx_d      = UART_IDLE_LVL;
          stopcnt_d = 2'd0;
          state_d   = T_STOP;
        end
      end
      T_STOP: begin
        if (i_bd) begin
          if (stopcnt_q < 2'(STOP_BITS - 1)) begin
            stopcnt_d = stopcnt_q + 2'd1;
          end else begin
            done_d = 1'b1;
            if (hold_vld_q) begin
              load = 1'b1;
            end else begin
              tx_d    = UART_IDLE_LVL;
              state_d = T_IDLE;
            end
          end
        end
      end
      default: begin
        tx_d    = UART_IDLE_LVL;
        state_d = T_IDLE;
      end
    endcase

    // Freeing the holder here lets the producer queue the next byte for the whole frame.
    if (load) begin
      shift_d    = hold_q;
      par_d      = hold_par_q;
      hold_vld_d = 1'b0;
      tx_d       = UART_START_LVL;
      state_d    = T_START;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= T_IDLE;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      hold_par_q <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      bitcnt_q   <= 3'd0;
      stopcnt_q  <= 2'd0;
      tx_q       <= UART_IDLE_LVL;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      hold_par_q <= hold_par_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      bitcnt_q   <= bitcnt_d;
      stopcnt_q  <= stopcnt_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign tx_if.o_tx_ready = ~hold_vld_q;
  assign o_tx             = tx_q;
  assign o_busy           = (state_q != T_IDLE) | hold_vld_q;
  assign o_done           = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations (8N1, 8E2, 8O1) checked against a frame-level model.
module tb_uart_tx;

  logic clk;
  logic rst;
  logic bd;
  int   bd_cnt;

  logic tx_w   [3];
  logic busy_w [3];
  logic done_w [3];

  uart_tx_if #(.DATA_BITS(8)) if0 ();
  uart_tx_if #(.DATA_BITS(8)) if1 ();
  uart_tx_if #(.DATA_BITS(8)) if2 ();

  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_bd(bd), .tx_if(if0),
    .o_tx(tx_w[0]), .o_busy(busy_w[0]), .o_done(done_w[0]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_bd(bd), .tx_if(if1),
    .o_tx(tx_w[1]), .o_busy(busy_w[1]), .o_done(done_w[1]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_bd(bd), .tx_if(if2),
    .o_tx(tx_w[2]), .o_busy(busy_w[2]), .o_done(done_w[2]));

  // Frame format of each instance, stated independently of the RTL.
  function automatic int cfg_par(input int s);
    return (s != 0) ? 1 : 0;
  endfunction
  function automatic int cfg_odd(input int s);
    return (s == 2) ? 1 : 0;
  endfunction
  function automatic int cfg_stop(input int s);
    return (s == 1) ? 2 : 1;
  endfunction

  int         n_checks;
  int         n_fail;
  int         cur_sel;
  int         done_cnt [3];
  logic [7:0] exp_q [$];

  logic mon_tx, mon_rdy, mon_busy, mon_done;

  always_comb begin
    mon_tx   = tx_w[0];
    mon_busy = busy_w[0];
    mon_done = done_w[0];
    mon_rdy  = if0.o_tx_ready;
    case (cur_sel)
      1: begin
        mon_tx = tx_w[1]; mon_busy = busy_w[1]; mon_done = done_w[1]; mon_rdy = if1.o_tx_ready;
      end
      2: begin
        mon_tx = tx_w[2]; mon_busy = busy_w[2]; mon_done = done_w[2]; mon_rdy = if2.o_tx_ready;
      end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    bd     = 1'b0;
    bd_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      bd_cnt = (bd_cnt + 1) % 16;
      bd     = (bd_cnt == 0);
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (done_w[k] === 1'b1) done_cnt[k] = done_cnt[k] + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic v, input logic [7:0] d);
    case (cur_sel)
      1:       begin if1.i_tx_valid = v; if1.i_tx_data = d; end
      2:       begin if2.i_tx_valid = v; if2.i_tx_data = d; end
      default: begin if0.i_tx_valid = v; if0.i_tx_data = d; end
    endcase
  endtask

  task automatic send(input logic [7:0] d);
    int t;
    t = 0;
    @(negedge clk);
    while (mon_rdy !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (mon_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready sel=%0d: ready=%b, required 1 within 3000 cycles", cur_sel, mon_rdy);
    end else begin
      drive(1'b1, d);
      exp_q.push_back(d);
      @(posedge clk);
      #1;
      drive(1'b0, 8'h00);
    end
  endtask

  // Waits for a start bit, then checks every bit of the frame for exactly 16 clocks.
  task automatic check_frame(output int gap, output logic rdy0);
    int         t;
    int         nb;
    int         bad;
    logic [11:0] bits;
    logic [7:0] d;
    gap  = -1;
    rdy0 = 1'b0;
    t    = 0;
    @(negedge clk);
    while (mon_tx !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (mon_tx !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_start sel=%0d: tx=%b, required start bit 0 within 3000 cycles", cur_sel, mon_tx);
      return;
    end
    gap  = t;
    rdy0 = mon_rdy;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL frame_expected sel=%0d: frame started with 0 bytes queued, required at least 1", cur_sel);
      return;
    end
    d    = exp_q.pop_front();
    bits = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    nb = 9;
    if (cfg_par(cur_sel) != 0) begin
      bits[nb] = (^d) ^ (cfg_odd(cur_sel) != 0);
      nb++;
    end
    for (int i = 0; i < cfg_stop(cur_sel); i++) begin
      bits[nb] = 1'b1;
      nb++;
    end
    for (int b = 0; b < nb; b++) begin
      bad = 0;
      for (int j = 0; j < 16; j++) begin
        if (b > 0 || j > 0) @(negedge clk);
        if (mon_tx !== bits[b]) bad++;
      end
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL frame_bit sel=%0d byte=%02h bit=%0d: wrong on %0d of 16 clocks, required %b",
                 cur_sel, d, b, bad, bits[b]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        cur_sel = k;
        #0;
        n_checks++;
        if ({mon_tx, mon_rdy, mon_busy, mon_done} !== 4'b1100) begin
          n_fail++;
          $display("FAIL reset_state sel=%0d cycle=%0d: {tx,rdy,busy,done}=%b, required 1100",
                   k, c, {mon_tx, mon_rdy, mon_busy, mon_done});
        end
      end
      @(posedge clk);
    end
    #1;
    rst     = 1'b0;
    cur_sel = 0;
  endtask

  task automatic test_8n1();
    int   g;
    logic r;
    int   c0;
    cur_sel = 0;
    c0 = done_cnt[0];
    fork
      send(8'hA5);
      check_frame(g, r);
    join
    n_checks++;
    if (g < 1 || g > 16) begin
      n_fail++;
      $display("FAIL start_latency: %0d clocks from accept to start bit, required 1..16", g);
    end
    @(negedge clk);
    n_checks++;
    if ({mon_done, mon_busy, mon_tx} !== 3'b101) begin
      n_fail++;
      $display("FAIL done_end_8n1: {done,busy,tx}=%b, required 101", {mon_done, mon_busy, mon_tx});
    end
    @(negedge clk);
    n_checks++;
    if (mon_done !== 1'b0 || done_cnt[0] - c0 != 1) begin
      n_fail++;
      $display("FAIL done_once_8n1: done=%b pulses=%0d, required done=0 pulses=1", mon_done, done_cnt[0] - c0);
    end
  endtask

  task automatic test_back_to_back();
    int   g1, g2;
    logic r1, r2;
    int   c0;
    cur_sel = 0;
    c0 = done_cnt[0];
    fork
      begin
        send(8'h55);
        repeat (40) @(negedge clk);
        send(8'h0F);
        @(negedge clk);
        n_checks++;
        if (mon_rdy !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_ready_low: ready=%b after second accept, required 0", mon_rdy);
        end
      end
      begin
        check_frame(g1, r1);
        check_frame(g2, r2);
      end
    join
    n_checks++;
    if (g2 != 0 || r2 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_gap: gap=%0d ready_at_start=%b, required gap=0 ready=1", g2, r2);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (done_cnt[0] - c0 != 2) begin
      n_fail++;
      $display("FAIL b2b_done_count: %0d pulses, required 2", done_cnt[0] - c0);
    end
  endtask

  task automatic test_parity();
    int   g;
    logic r;
    for (int s = 1; s < 3; s++) begin
      cur_sel = s;
      fork
        send(8'h07);
        check_frame(g, r);
      join
      @(negedge clk);
      n_checks++;
      if (mon_done !== 1'b1 || mon_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL parity_done sel=%0d: done=%b busy=%b, required done=1 busy=0", s, mon_done, mon_busy);
      end
    end
    cur_sel = 0;
  endtask

  task automatic test_reset_midframe();
    int   t;
    int   bad;
    int   c0;
    int   g;
    logic r;
    cur_sel = 0;
    send(8'hA5);
    t = 0;
    while (mon_tx !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    send(8'hFF);
    repeat (16 * 4 + 5 - 1) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mon_tx, mon_rdy, mon_busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL midframe_reset: {tx,rdy,busy}=%b, required 110", {mon_tx, mon_rdy, mon_busy});
    end
    exp_q.delete();
    c0  = done_cnt[0];
    bad = 0;
    repeat (250) begin
      @(negedge clk);
      if (mon_tx !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0 || done_cnt[0] != c0) begin
      n_fail++;
      $display("FAIL midframe_discard: tx low on %0d clocks, %0d done pulses, required 0 and 0",
               bad, done_cnt[0] - c0);
    end
    fork
      send(8'h3C);
      check_frame(g, r);
    join
  endtask

  task automatic test_flow_control();
    int   acc;
    int   g;
    logic r;
    cur_sel = 0;
    acc = 0;
    fork
      begin
        int t;
        t = 0;
        while (acc < 3 && t < 3000) begin
          logic [7:0] d;
          @(negedge clk);
          d = 8'($urandom);
          drive(1'b1, d);
          if (mon_rdy === 1'b1) begin
            exp_q.push_back(d);
            acc++;
          end
          t++;
        end
        @(posedge clk);
        #1;
        drive(1'b0, 8'h00);
      end
      begin
        for (int k = 0; k < 3; k++) check_frame(g, r);
      end
    join
    n_checks++;
    if (acc != 3 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL flow_accepts: accepted=%0d leftover=%0d, required 3 and 0", acc, exp_q.size());
    end
  endtask

  task automatic test_random();
    int   g;
    logic r;
    for (int s = 0; s < 3; s++) begin
      cur_sel = s;
      fork
        begin
          for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 200)) @(negedge clk);
            send(8'($urandom));
          end
        end
        begin
          for (int k = 0; k < 4; k++) check_frame(g, r);
        end
      join
      repeat (20) @(negedge clk);
    end
    cur_sel = 0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cur_sel  = 0;
    for (int k = 0; k < 3; k++) done_cnt[k] = 0;
    if0.i_tx_valid = 1'b0; if0.i_tx_data = 8'h00;
    if1.i_tx_valid = 1'b0; if1.i_tx_data = 8'h00;
    if2.i_tx_valid = 1'b0; if2.i_tx_data = 8'h00;
    rst = 1'b1;

    test_reset();
    repeat (5) @(negedge clk);
    test_8n1();
    repeat (30) @(negedge clk);
    test_back_to_back();
    repeat (30) @(negedge clk);
    test_parity();
    repeat (30) @(negedge clk);
    test_reset_midframe();
    repeat (30) @(negedge clk);
    test_flow_control();
    repeat (30) @(negedge clk);
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
